// File: rtl/nasti_channel_slice.sv
// nasti_channel_slice: per-port, per-channel FIFO buffering stage between an
// upstream (s) and a downstream (m) NASTI bundle of N_PORT ports.
//   clk, rst      : clock and asynchronous active-high reset
//   s_aw/s_w/s_ar : request channels from the external master (buffered to m_*)
//   m_b/m_r       : response channels from the external slave (buffered to s_*)
//   idle[p]       : high when every FIFO of port p holds zero entries
// A channel depth of 0 turns that channel into plain wires.
// Each per-port field is packed into a flat vector, with port p at slice p.

// Single channel FIFO.
// x = upstream (producer) side, y = downstream (consumer) side.
// The FIFO never bypasses: a beat accepted on x appears on y one cycle later,
// and x_ready depends only on the registered count.
module nasti_channel_slice_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [WIDTH-1:0] x_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             empty
);

  if (DEPTH == 0) begin : g_wire
    assign y_valid = x_valid;
    assign x_ready = y_ready;
    assign y_data  = x_data;
    assign empty   = 1'b1;
  end else begin : g_fifo
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign x_ready = (count != CW'(DEPTH));
    assign y_valid = (count != '0);
    assign y_data  = mem[rd_ptr];
    assign empty   = (count == '0);
    assign push    = x_valid & x_ready;
    assign pop     = y_valid & y_ready;

    // Circular buffer; the pointers wrap explicitly so any depth is legal.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        mem    <= '{default: '0};
      end else begin
        if (push) begin
          mem[wr_ptr] <= x_data;
          wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Upstream must hold valid and payload steady while it is being stalled.
  a_x_stable: assert property (@(posedge clk) disable iff (rst)
    (x_valid && !x_ready) |=> (x_valid && $stable(x_data)))
    else $error("nasti_channel_slice: upstream valid/payload changed while stalled");

endmodule

module nasti_channel_slice #(
  parameter int unsigned N_PORT     = 1,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned AW_DEPTH   = 1,
  parameter int unsigned W_DEPTH    = 2,
  parameter int unsigned B_DEPTH    = 1,
  parameter int unsigned AR_DEPTH   = 1,
  parameter int unsigned R_DEPTH    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  // upstream AW
  input  logic [N_PORT-1:0]              s_aw_valid,
  output logic [N_PORT-1:0]              s_aw_ready,
  input  logic [N_PORT*ID_WIDTH-1:0]     s_aw_id,
  input  logic [N_PORT*ADDR_WIDTH-1:0]   s_aw_addr,
  input  logic [N_PORT*8-1:0]            s_aw_len,
  input  logic [N_PORT*3-1:0]            s_aw_size,
  input  logic [N_PORT*2-1:0]            s_aw_burst,
  input  logic [N_PORT-1:0]              s_aw_lock,
  input  logic [N_PORT*4-1:0]            s_aw_cache,
  input  logic [N_PORT*3-1:0]            s_aw_prot,
  input  logic [N_PORT*4-1:0]            s_aw_qos,
  input  logic [N_PORT*4-1:0]            s_aw_region,
  input  logic [N_PORT*USER_WIDTH-1:0]   s_aw_user,
  // upstream W
  input  logic [N_PORT-1:0]              s_w_valid,
  output logic [N_PORT-1:0]              s_w_ready,
  input  logic [N_PORT*DATA_WIDTH-1:0]   s_w_data,
  input  logic [N_PORT*DATA_WIDTH/8-1:0] s_w_strb,
  input  logic [N_PORT-1:0]              s_w_last,
  input  logic [N_PORT*USER_WIDTH-1:0]   s_w_user,
  // upstream B
  output logic [N_PORT-1:0]              s_b_valid,
  input  logic [N_PORT-1:0]              s_b_ready,
  output logic [N_PORT*ID_WIDTH-1:0]     s_b_id,
  output logic [N_PORT*2-1:0]            s_b_resp,
  output logic [N_PORT*USER_WIDTH-1:0]   s_b_user,
  // upstream AR
  input  logic [N_PORT-1:0]              s_ar_valid,
  output logic [N_PORT-1:0]              s_ar_ready,
  input  logic [N_PORT*ID_WIDTH-1:0]     s_ar_id,
  input  logic [N_PORT*ADDR_WIDTH-1:0]   s_ar_addr,
  input  logic [N_PORT*8-1:0]            s_ar_len,
  input  logic [N_PORT*3-1:0]            s_ar_size,
  input  logic [N_PORT*2-1:0]            s_ar_burst,
  input  logic [N_PORT-1:0]              s_ar_lock,
  input  logic [N_PORT*4-1:0]            s_ar_cache,
  input  logic [N_PORT*3-1:0]            s_ar_prot,
  input  logic [N_PORT*4-1:0]            s_ar_qos,
  input  logic [N_PORT*4-1:0]            s_ar_region,
  input  logic [N_PORT*USER_WIDTH-1:0]   s_ar_user,
  // upstream R
  output logic [N_PORT-1:0]              s_r_valid,
  input  logic [N_PORT-1:0]              s_r_ready,
  output logic [N_PORT*ID_WIDTH-1:0]     s_r_id,
  output logic [N_PORT*DATA_WIDTH-1:0]   s_r_data,
  output logic [N_PORT*2-1:0]            s_r_resp,
  output logic [N_PORT-1:0]              s_r_last,
  output logic [N_PORT*USER_WIDTH-1:0]   s_r_user,
  // downstream AW
  output logic [N_PORT-1:0]              m_aw_valid,
  input  logic [N_PORT-1:0]              m_aw_ready,
  output logic [N_PORT*ID_WIDTH-1:0]     m_aw_id,
  output logic [N_PORT*ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [N_PORT*8-1:0]            m_aw_len,
  output logic [N_PORT*3-1:0]            m_aw_size,
  output logic [N_PORT*2-1:0]            m_aw_burst,
  output logic [N_PORT-1:0]              m_aw_lock,
  output logic [N_PORT*4-1:0]            m_aw_cache,
  output logic [N_PORT*3-1:0]            m_aw_prot,
  output logic [N_PORT*4-1:0]            m_aw_qos,
  output logic [N_PORT*4-1:0]            m_aw_region,
  output logic [N_PORT*USER_WIDTH-1:0]   m_aw_user,
  // downstream W
  output logic [N_PORT-1:0]              m_w_valid,
  input  logic [N_PORT-1:0]              m_w_ready,
  output logic [N_PORT*DATA_WIDTH-1:0]   m_w_data,
  output logic [N_PORT*DATA_WIDTH/8-1:0] m_w_strb,
  output logic [N_PORT-1:0]              m_w_last,
  output logic [N_PORT*USER_WIDTH-1:0]   m_w_user,
  // downstream B
  input  logic [N_PORT-1:0]              m_b_valid,
  output logic [N_PORT-1:0]              m_b_ready,
  input  logic [N_PORT*ID_WIDTH-1:0]     m_b_id,
  input  logic [N_PORT*2-1:0]            m_b_resp,
  input  logic [N_PORT*USER_WIDTH-1:0]   m_b_user,
  // downstream AR
  output logic [N_PORT-1:0]              m_ar_valid,
  input  logic [N_PORT-1:0]              m_ar_ready,
  output logic [N_PORT*ID_WIDTH-1:0]     m_ar_id,
  output logic [N_PORT*ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [N_PORT*8-1:0]            m_ar_len,
  output logic [N_PORT*3-1:0]            m_ar_size,
  output logic [N_PORT*2-1:0]            m_ar_burst,
  output logic [N_PORT-1:0]              m_ar_lock,
  output logic [N_PORT*4-1:0]            m_ar_cache,
  output logic [N_PORT*3-1:0]            m_ar_prot,
  output logic [N_PORT*4-1:0]            m_ar_qos,
  output logic [N_PORT*4-1:0]            m_ar_region,
  output logic [N_PORT*USER_WIDTH-1:0]   m_ar_user,
  // downstream R
  input  logic [N_PORT-1:0]              m_r_valid,
  output logic [N_PORT-1:0]              m_r_ready,
  input  logic [N_PORT*ID_WIDTH-1:0]     m_r_id,
  input  logic [N_PORT*DATA_WIDTH-1:0]   m_r_data,
  input  logic [N_PORT*2-1:0]            m_r_resp,
  input  logic [N_PORT-1:0]              m_r_last,
  input  logic [N_PORT*USER_WIDTH-1:0]   m_r_user,
  // status
  output logic [N_PORT-1:0]              idle
);

  localparam int unsigned IW   = ID_WIDTH;
  localparam int unsigned AWD  = ADDR_WIDTH;
  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned SW   = DATA_WIDTH / 8;
  localparam int unsigned UW   = USER_WIDTH;
  localparam int unsigned AX_W = IW + AWD + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + UW;
  localparam int unsigned W_W  = DW + SW + 1 + UW;
  localparam int unsigned B_W  = IW + 2 + UW;
  localparam int unsigned R_W  = IW + DW + 2 + 1 + UW;

  // Elaboration-time parameter checks.
  if (USER_WIDTH == 0) begin : g_chk_user
    $fatal(1, "nasti_channel_slice: USER_WIDTH must be > 0");
  end
  if (AW_DEPTH > 16 || W_DEPTH > 16 || B_DEPTH > 16 || AR_DEPTH > 16 || R_DEPTH > 16)
  begin : g_chk_depth
    $fatal(1, "nasti_channel_slice: channel depth exceeds 16");
  end

  for (genvar p = 0; p < int'(N_PORT); p++) begin : g_port
    logic [AX_W-1:0] aw_x, aw_y, ar_x, ar_y;
    logic [W_W-1:0]  w_x, w_y;
    logic [B_W-1:0]  b_x, b_y;
    logic [R_W-1:0]  r_x, r_y;
    logic            aw_empty, w_empty, b_empty, ar_empty, r_empty;

    // Beat packing: fields carried unmodified in a fixed order.
    assign aw_x = {s_aw_id[p*IW +: IW], s_aw_addr[p*AWD +: AWD], s_aw_len[p*8 +: 8],
                   s_aw_size[p*3 +: 3], s_aw_burst[p*2 +: 2], s_aw_lock[p],
                   s_aw_cache[p*4 +: 4], s_aw_prot[p*3 +: 3], s_aw_qos[p*4 +: 4],
                   s_aw_region[p*4 +: 4], s_aw_user[p*UW +: UW]};
    assign {m_aw_id[p*IW +: IW], m_aw_addr[p*AWD +: AWD], m_aw_len[p*8 +: 8],
            m_aw_size[p*3 +: 3], m_aw_burst[p*2 +: 2], m_aw_lock[p],
            m_aw_cache[p*4 +: 4], m_aw_prot[p*3 +: 3], m_aw_qos[p*4 +: 4],
            m_aw_region[p*4 +: 4], m_aw_user[p*UW +: UW]} = aw_y;

    assign ar_x = {s_ar_id[p*IW +: IW], s_ar_addr[p*AWD +: AWD], s_ar_len[p*8 +: 8],
                   s_ar_size[p*3 +: 3], s_ar_burst[p*2 +: 2], s_ar_lock[p],
                   s_ar_cache[p*4 +: 4], s_ar_prot[p*3 +: 3], s_ar_qos[p*4 +: 4],
                   s_ar_region[p*4 +: 4], s_ar_user[p*UW +: UW]};
    assign {m_ar_id[p*IW +: IW], m_ar_addr[p*AWD +: AWD], m_ar_len[p*8 +: 8],
            m_ar_size[p*3 +: 3], m_ar_burst[p*2 +: 2], m_ar_lock[p],
            m_ar_cache[p*4 +: 4], m_ar_prot[p*3 +: 3], m_ar_qos[p*4 +: 4],
            m_ar_region[p*4 +: 4], m_ar_user[p*UW +: UW]} = ar_y;

    assign w_x = {s_w_data[p*DW +: DW], s_w_strb[p*SW +: SW], s_w_last[p],
                  s_w_user[p*UW +: UW]};
    assign {m_w_data[p*DW +: DW], m_w_strb[p*SW +: SW], m_w_last[p],
            m_w_user[p*UW +: UW]} = w_y;

    assign b_x = {m_b_id[p*IW +: IW], m_b_resp[p*2 +: 2], m_b_user[p*UW +: UW]};
    assign {s_b_id[p*IW +: IW], s_b_resp[p*2 +: 2], s_b_user[p*UW +: UW]} = b_y;

    assign r_x = {m_r_id[p*IW +: IW], m_r_data[p*DW +: DW], m_r_resp[p*2 +: 2],
                  m_r_last[p], m_r_user[p*UW +: UW]};
    assign {s_r_id[p*IW +: IW], s_r_data[p*DW +: DW], s_r_resp[p*2 +: 2],
            s_r_last[p], s_r_user[p*UW +: UW]} = r_y;

    nasti_channel_slice_fifo #(.WIDTH(AX_W), .DEPTH(AW_DEPTH)) u_aw (
      .clk(clk), .rst(rst),
      .x_valid(s_aw_valid[p]), .x_ready(s_aw_ready[p]), .x_data(aw_x),
      .y_valid(m_aw_valid[p]), .y_ready(m_aw_ready[p]), .y_data(aw_y),
      .empty(aw_empty));

    nasti_channel_slice_fifo #(.WIDTH(W_W), .DEPTH(W_DEPTH)) u_w (
      .clk(clk), .rst(rst),
      .x_valid(s_w_valid[p]), .x_ready(s_w_ready[p]), .x_data(w_x),
      .y_valid(m_w_valid[p]), .y_ready(m_w_ready[p]), .y_data(w_y),
      .empty(w_empty));

    nasti_channel_slice_fifo #(.WIDTH(B_W), .DEPTH(B_DEPTH)) u_b (
      .clk(clk), .rst(rst),
      .x_valid(m_b_valid[p]), .x_ready(m_b_ready[p]), .x_data(b_x),
      .y_valid(s_b_valid[p]), .y_ready(s_b_ready[p]), .y_data(b_y),
      .empty(b_empty));

    nasti_channel_slice_fifo #(.WIDTH(AX_W), .DEPTH(AR_DEPTH)) u_ar (
      .clk(clk), .rst(rst),
      .x_valid(s_ar_valid[p]), .x_ready(s_ar_ready[p]), .x_data(ar_x),
      .y_valid(m_ar_valid[p]), .y_ready(m_ar_ready[p]), .y_data(ar_y),
      .empty(ar_empty));

    nasti_channel_slice_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
      .clk(clk), .rst(rst),
      .x_valid(m_r_valid[p]), .x_ready(m_r_ready[p]), .x_data(r_x),
      .y_valid(s_r_valid[p]), .y_ready(s_r_ready[p]), .y_data(r_y),
      .empty(r_empty));

    assign idle[p] = aw_empty & w_empty & b_empty & ar_empty & r_empty;
  end

endmodule

// File: doc/nasti_channel_slice.md
Name: nasti_channel_slice

Overview:
- Parametrised buffering stage for the nasti_channel interface. It sits between a master-side and a slave-side nasti_channel bundle of N_PORT ports.
- Each of the five channels (AW, W, B, R, AR) on each port gets an independent FIFO of configurable depth. Depth 0 means a combinational pass-through.
- Used to break timing paths and absorb bursts between crossbar, cache and peripheral bridges. The idle output supports clock gating and safe-reset checks.

Parameters:
- N_PORT, 1, number of NASTI ports carried in each interface bundle.
- ID_WIDTH, 1, id width.
- ADDR_WIDTH, 8, address width.
- DATA_WIDTH, 8, data width; must be a multiple of 8.
- USER_WIDTH, 1, user width; must be >0 (elaboration $fatal otherwise).
- AW_DEPTH, 1, AW FIFO entries per port (0..16).
- W_DEPTH, 2, W FIFO entries per port (0..16).
- B_DEPTH, 1, B FIFO entries per port (0..16).
- AR_DEPTH, 1, AR FIFO entries per port (0..16).
- R_DEPTH, 2, R FIFO entries per port (0..16).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s  nasti_channel.slave  interface  upstream side; an external master drives it.
- m  nasti_channel.master  interface  downstream side; drives an external slave.
- idle  output  N_PORT  bit p is high when all five FIFOs of port p hold zero entries.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Port mapping: each channel instance sits on port p, with upstream X and downstream Y.
  - AW, W, AR: upstream is s, downstream is m.
  - B, R: upstream is m, downstream is s.
- Payload packing per beat, fields in listed order:
  - AW/AR: id, addr, len, size, burst, lock, cache, prot, qos, region, user.
  - W: data, strb, last, user.
  - B: id, resp, user.
  - R: id, data, resp, last, user.
  - Fields are carried unmodified.
- DEPTH = 0: pure wires.
  - Y.valid = X.valid; X.ready = Y.ready; payload passes through.
  - Zero latency, no state; idle contribution is constant 1.
- DEPTH = D ≥ 1: circular buffer with D entries, rd_ptr, wr_ptr, and count of width $clog2(D+1).
  - Pointers wrap from D-1 to 0; non-power-of-2 D is legal.
  - X.ready = (count != D). It depends only on registers, never combinationally on Y.ready.
  - Y.valid = (count != 0). Y payload = mem[rd_ptr], driven from the registered array.
  - push = X.valid & X.ready: writes mem[wr_ptr] and advances wr_ptr.
  - pop = Y.valid & Y.ready: advances rd_ptr.
  - count' = count + push - pop. Simultaneous push and pop leaves count unchanged.
  - When full, push is refused even if pop happens in the same cycle; no full bypass.
  - When empty, no data bypass: a pushed beat appears on Y exactly 1 cycle after acceptance.
  - D=1 therefore sustains at most 1 beat per 2 cycles. D ≥ 2 sustains 1 beat/cycle with a continuously ready downstream.
- Ordering: strict FIFO per channel per port. Channels and ports are fully independent.
  - No AW/W coupling; W may lead AW.
  - No id reordering.
- Handshake rules:
  - Once Y.valid is high, payload holds stable until pop.
  - X.valid held while X.ready is low is accepted no later than the cycle after a slot frees.
- Reset (rst high, asynchronous):
  - count, rd_ptr and wr_ptr go to 0. All downstream valids go to 0 immediately, without waiting for clk.
  - X.ready goes to 1 for D≥1. Storage clears to 0. idle goes to all-ones.
  - Reset mid-burst discards buffered beats; none are replayed after release.
- idle[p] = AND over channels of (count==0), registered-count derived. It is low in the cycle after any push until the last pop completes.
- Assertions (simulation only):
  - Fatal on any DEPTH > 16.
  - Error if X.valid drops or payload changes while X.valid & !X.ready.

Test Plan:
- Reset: assert rst mid-cycle with 2 beats in W (W_DEPTH=2) -> m.w_valid=0 the same time step, s.w_ready=1, idle=1. After release, no stale beat emerges.
- Latency/ordering: AW_DEPTH=1. Push aw_addr=0x10, id=1 at cycle 0 with m.aw_ready=1 -> m.aw_valid at cycle 1 with addr 0x10, id 1. s.aw_ready=0 in cycle 1, 1 again in cycle 2.
- Throughput: R_DEPTH=2. Slave streams 8 beats r_data=0..7, r_last on beat 7; s.r_ready held 1 -> 8 beats out in order over 9 cycles, last only on 7, no bubbles after the first.
- Backpressure/full: W_DEPTH=4. Downstream w_ready=0, master offers 6 beats -> 4 accepted, s.w_ready=0. Assert w_ready -> beats 0..5 emerge in order, and no push occurs in the cycle full and pop coincide.
- Pass-through: B_DEPTH=0 -> s.b_valid/b_id/b_resp equal m.b_* in the same cycle; m.b_ready equals s.b_ready combinationally.
- Multi-port independence: N_PORT=2. Stall port 0 AR (ar_ready=0) while port 1 streams 4 ARs -> port 1 completes all 4. idle=2'b10 until port 0 drains, then 2'b11.
